// File: rtl/regfile_pkg.sv
// Shared constants and packed-port slicing helpers for the multi-port register file.
package regfile_pkg;

  localparam int ZERO_REG  = 0;
  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NREAD  = 2;
  localparam int RF_NWRITE = 2;

  // Helpers see packed buses through a fixed 256-bit window and fields up to 64 bits
  localparam int RF_VEC_MAX = 256;

  function automatic logic [15:0] slice_addr(input logic [RF_VEC_MAX-1:0] vec,
                                             input int k, input int aw);
    logic [RF_VEC_MAX-1:0] sh;
    sh = vec >> (k * aw);
    return 16'(sh) & 16'((32'(1) << aw) - 32'(1));
  endfunction

  function automatic logic [63:0] slice_data(input logic [RF_VEC_MAX-1:0] vec,
                                             input int k, input int w);
    logic [RF_VEC_MAX-1:0] sh;
    sh = vec >> (k * w);
    return 64'(sh) & ((64'(1) << w) - 64'(1));
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: write, read and reserve ports.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NREAD  = RF_NREAD,
  parameter int NWRITE = RF_NWRITE
);
  localparam int AW = $clog2(DEPTH);

  logic [NWRITE-1:0]       WE;
  logic [NWRITE*AW-1:0]    WA;
  logic [NWRITE*WIDTH-1:0] WD;
  logic [NREAD-1:0]        RE;
  logic [NREAD*AW-1:0]     RA;
  logic [NREAD*WIDTH-1:0]  RD;
  logic                    RSV;
  logic [AW-1:0]           RSV_A;
  logic [NREAD-1:0]        BUSY;

  modport master (output WE, WA, WD, RE, RA, RSV, RSV_A, input RD, BUSY);
  modport slave  (input WE, WA, WD, RE, RA, RSV, RSV_A, output RD, BUSY);
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection; reserve beats a same-cycle writeback clear.
// With REGFILE_BYPASS_EN a same-cycle clear is visible on BUSY immediately.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int NREAD  = RF_NREAD,
  parameter int NWRITE = RF_NWRITE,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NWRITE-1:0]            wclr,
  input  logic [NWRITE-1:0][AW-1:0]    wclr_a,
  input  logic                         rsv,
  input  logic [AW-1:0]                rsv_a,
`ifdef REGFILE_BYPASS_EN
  input  logic [NREAD-1:0]             re,
`endif
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0]             busy
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             rsv_hit;

  assign rsv_hit = rsv && (rsv_a != AW'(ZERO_REG));

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWRITE; k++)
      if (wclr[k] && wclr_a[k] != AW'(ZERO_REG)) busy_d[wclr_a[k]] = 1'b0;
    if (rsv_hit) busy_d[rsv_a] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_lookup
    logic b;
    always_comb begin
      b = busy_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
      if (re[i] && ra[i] != AW'(ZERO_REG) && !(rsv_hit && rsv_a == ra[i]))
        for (int k = 0; k < NWRITE; k++)
          if (wclr[k] && wclr_a[k] == ra[i]) b = 1'b0;
`endif
    end
    assign busy[i] = b;
  end

endmodule

// File: rtl/regfile_mp.sv
// NREAD x NWRITE register file, r0 hardwired to zero, with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NREAD  = RF_NREAD,
  parameter int NWRITE = RF_NWRITE
) (
  input  logic        clock,
  input  logic        reset_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [NWRITE-1:0][AW-1:0]    wa;
  logic [NWRITE-1:0][WIDTH-1:0] wd;
  logic [NREAD-1:0][AW-1:0]     ra;
  logic [NREAD-1:0][WIDTH-1:0]  rdata;
  logic [WIDTH-1:0]             ram [DEPTH];

  for (genvar k = 0; k < NWRITE; k++) begin : g_wsl
    assign wa[k] = AW'(slice_addr(RF_VEC_MAX'(bus.WA), k, AW));
    assign wd[k] = WIDTH'(slice_data(RF_VEC_MAX'(bus.WD), k, WIDTH));
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rsl
    assign ra[i] = AW'(slice_addr(RF_VEC_MAX'(bus.RA), i, AW));
  end

  // Ascending port order: the last NBA, i.e. the highest-index port, wins a collision
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) ram[r] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++)
        if (bus.WE[k] && wa[k] != AW'(ZERO_REG)) ram[wa[k]] <= wd[k];
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [WIDTH-1:0] rv;
    always_comb begin
      rv = '0;
      if (reset_n && bus.RE[i] && ra[i] != AW'(ZERO_REG)) begin
        rv = ram[ra[i]];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWRITE; k++)
          if (bus.WE[k] && wa[k] == ra[i]) rv = wd[k];
`endif
      end
    end
    assign rdata[i] = rv;
  end

  assign bus.RD = rdata;

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NREAD (NREAD),
    .NWRITE(NWRITE),
    .AW    (AW)
  ) u_sb (
    .clock  (clock),
    .reset_n(reset_n),
    .wclr   (bus.WE),
    .wclr_a (wa),
    .rsv    (bus.RSV),
    .rsv_a  (bus.RSV_A),
`ifdef REGFILE_BYPASS_EN
    .re     (bus.RE),
`endif
    .ra     (ra),
    .busy   (bus.BUSY)
  );

endmodule
